// File: rtl/seg7_display_arbiter.sv
// Four-digit seven-segment scan controller shared between two requesters.
// Ownership moves only at frame boundaries. The owner's value is latched once per
// frame, so a frame never shows digits from two different values.
module seg7_display_arbiter #(
  parameter int unsigned SCAN_DIV     = 65536,
  parameter int unsigned BLANK_CYCLES = 256,
  parameter int unsigned HOLD_FRAMES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [15:0] val_a,
  input  logic        req_b,
  input  logic [15:0] val_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [6:0]  display,
  output logic [3:0]  grounds,
  output logic        frame_tick
);

  localparam int unsigned DivW  = $clog2(SCAN_DIV);
  localparam int unsigned HoldW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [DivW-1:0]  DivMax   = DivW'(SCAN_DIV - 1);
  localparam logic [DivW-1:0]  BlankLim = DivW'(BLANK_CYCLES);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_FRAMES - 1);
  localparam logic [6:0]       SegDash  = 7'b0000001;

  // Reject parameter sets that would break the scan timing.
  if (SCAN_DIV < 2) begin : gen_bad_div
    $error("SCAN_DIV must be at least 2");
  end
  if (BLANK_CYCLES >= SCAN_DIV) begin : gen_bad_blank
    $error("BLANK_CYCLES must be smaller than SCAN_DIV");
  end
  if (HOLD_FRAMES < 1) begin : gen_bad_hold
    $error("HOLD_FRAMES must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StOwnA,
    StOwnB
  } state_e;

  logic [DivW-1:0]  div_cnt;
  logic [1:0]       idx;
  state_e           state;
  state_e           next_state;
  logic             last;      // 1: B was granted most recently, 0: A
  logic [HoldW-1:0] hold_cnt;
  logic [15:0]      shadow;
  logic             frame_end;
  logic [3:0]       digit;

  assign frame_end = (idx == 2'd3) && (div_cnt == DivMax);

  // Hex nibble to active-high {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // Slot divider and digit index; idx advances each time div_cnt wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (div_cnt == DivMax) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DivW'(1);
    end
  end

  // Arbitration decision; only consumed at frame end.
  always_comb begin
    next_state = state;
    unique case (state)
      StIdle: begin
        if (req_a && req_b) begin
          // Both waiting: hand the display to the side that did not have it last.
          next_state = last ? StOwnA : StOwnB;
        end else if (req_a) begin
          next_state = StOwnA;
        end else if (req_b) begin
          next_state = StOwnB;
        end
      end
      StOwnA: begin
        if (!req_a) begin
          // Release is immediate; the hold time only protects an active owner.
          next_state = req_b ? StOwnB : StIdle;
        end else if (req_b && (hold_cnt >= HoldMax)) begin
          next_state = StOwnB;
        end
      end
      StOwnB: begin
        if (!req_b) begin
          next_state = req_a ? StOwnA : StIdle;
        end else if (req_a && (hold_cnt >= HoldMax)) begin
          next_state = StOwnA;
        end
      end
      default: next_state = StIdle;
    endcase
  end

  // Ownership FSM, grants and value latch; everything moves at frame end only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      last     <= 1'b1;
      hold_cnt <= '0;
      shadow   <= 16'h0000;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
    end else if (frame_end) begin
      state <= next_state;
      gnt_a <= (next_state == StOwnA);
      gnt_b <= (next_state == StOwnB);

      if ((next_state != StIdle) && (next_state == state)) begin
        if (hold_cnt != HoldMax) begin
          hold_cnt <= hold_cnt + HoldW'(1);
        end
      end else begin
        hold_cnt <= '0;
      end

      // Idle keeps the old value latched; dashes are shown instead.
      if (next_state == StOwnA) begin
        shadow <= val_a;
        last   <= 1'b0;
      end else if (next_state == StOwnB) begin
        shadow <= val_b;
        last   <= 1'b1;
      end
    end
  end

  // Nibble for the current slot, leftmost digit first.
  always_comb begin
    digit = 4'h0;
    unique case (idx)
      2'd0: digit = shadow[15:12];
      2'd1: digit = shadow[11:8];
      2'd2: digit = shadow[7:4];
      2'd3: digit = shadow[3:0];
      default: digit = 4'h0;
    endcase
  end

  // Registered pin drive: blanking at the start of each slot, then one grounded digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grounds    <= 4'b1111;
      display    <= 7'b0000000;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (div_cnt < BlankLim) begin
        grounds <= 4'b1111;
        display <= 7'b0000000;
      end else begin
        grounds <= ~(4'b0001 << idx);
        display <= (state == StIdle) ? SegDash : hex_to_seg(digit);
      end
    end
  end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Bench for seg7_display_arbiter: a cycle-position reference model predicts the pins
// after every edge, a monitor compares them half a cycle later.
module tb_seg7_display_arbiter;

  localparam int SD = 8;
  localparam int BL = 2;
  localparam int HF = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [15:0] val_a = 16'h0000;
  logic [15:0] val_b = 16'h0000;
  logic        gnt_a;
  logic        gnt_b;
  logic [6:0]  display;
  logic [3:0]  grounds;
  logic        frame_tick;

  seg7_display_arbiter #(
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BL),
    .HOLD_FRAMES (HF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .val_a     (val_a),
    .req_b     (req_b),
    .val_b     (val_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .display   (display),
    .grounds   (grounds),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ga;
    logic       gb;
    logic [6:0] disp;
    logic [3:0] gnd;
    logic       tick;
  } obs_t;

  obs_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [6:0] seg_tab[16];

  // Reference state: owner 0 = nobody, 1 = A, 2 = B.
  int          m_cycle;
  int          m_owner;
  int          m_last;
  int          m_held;
  logic [15:0] m_shadow;

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  end

  // Predict the outputs that the coming edge produces, then advance the model.
  task automatic model_step();
    obs_t        e;
    int          slot;
    int          pos;
    bit          fe;
    int          nxt;
    bit          mine;
    bit          other;
    logic [15:0] sh;
    e = '0;
    if (!rst_n) begin
      m_cycle  = 0;
      m_owner  = 0;
      m_last   = 2;
      m_held   = 0;
      m_shadow = 16'h0000;
      e.gnd    = 4'hF;
    end else begin
      slot   = (m_cycle / SD) % 4;
      pos    = m_cycle % SD;
      fe     = (slot == 3) && (pos == SD - 1);
      e.tick = fe;
      if (pos < BL) begin
        e.gnd  = 4'hF;
        e.disp = 7'b0000000;
      end else begin
        e.gnd       = 4'hF;
        e.gnd[slot] = 1'b0;
        sh          = m_shadow >> (4 * (3 - slot));
        e.disp      = (m_owner == 0) ? 7'b0000001 : seg_tab[sh[3:0]];
      end
      if (fe) begin
        if (m_owner == 0) begin
          if (req_a && req_b) nxt = (m_last == 2) ? 1 : 2;
          else if (req_a)     nxt = 1;
          else if (req_b)     nxt = 2;
          else                nxt = 0;
        end else begin
          mine  = (m_owner == 1) ? req_a : req_b;
          other = (m_owner == 1) ? req_b : req_a;
          if (!mine)                          nxt = other ? 3 - m_owner : 0;
          else if (other && m_held >= HF - 1) nxt = 3 - m_owner;
          else                                nxt = m_owner;
        end
        if (nxt != 0 && nxt != m_owner) begin
          m_held = 0;
          m_last = nxt;
        end else if (nxt != 0) begin
          m_held++;
        end
        if (nxt == 1)      m_shadow = val_a;
        else if (nxt == 2) m_shadow = val_b;
        m_owner = nxt;
      end
      e.ga = (m_owner == 1);
      e.gb = (m_owner == 2);
      m_cycle++;
    end
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compare pins against the oldest prediction away from the active edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({gnt_a, gnt_b, display, grounds, frame_tick} !== e) begin
          errors++;
          $display("FAIL pins t=%0t got gnt=%b%b disp=%b gnd=%b tick=%b exp gnt=%b%b disp=%b gnd=%b tick=%b",
                   $time, gnt_a, gnt_b, display, grounds, frame_tick,
                   e.ga, e.gb, e.disp, e.gnd, e.tick);
        end
        checks++;
        if (gnt_a === 1'b1 && gnt_b === 1'b1) begin
          errors++;
          $display("FAIL gnt_onehot t=%0t got gnt=%b%b exp not both 1", $time, gnt_a, gnt_b);
        end
      end
    end
  end

  // Bounded wait for a grant; an expired budget counts as a failure.
  task automatic wait_grant(input bit side_b, input string name);
    int n;
    n = 0;
    while (((side_b ? gnt_b : gnt_a) !== 1'b1) && n < 34) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((side_b ? gnt_b : gnt_a) !== 1'b1) begin
      errors++;
      $display("FAIL %s got gnt=%b%b after %0d cycles exp grant within 33", name, gnt_a, gnt_b, n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Single requester.
    req_a = 1'b1;
    val_a = 16'h1A3F;
    wait_grant(1'b0, "grant_a_latency");
    repeat (40) @(negedge clk);

    // Value change mid-frame must wait for the next frame.
    repeat (10) @(negedge clk);
    val_a = 16'hBEEF;
    repeat (64) @(negedge clk);

    // Contention: alternates every HF frames.
    val_a = 16'h1111;
    val_b = 16'h2222;
    req_b = 1'b1;
    repeat (8 * 32) @(negedge clk);

    // B alone, then A takes over and releases at once while B waits.
    req_a = 1'b0;
    repeat (64) @(negedge clk);
    req_a = 1'b1;
    req_b = 1'b0;
    wait_grant(1'b0, "grant_a_after_b");
    req_a = 1'b0;
    req_b = 1'b1;
    wait_grant(1'b1, "release_to_b");
    checks++;
    if (gnt_a !== 1'b0) begin
      errors++;
      $display("FAIL release_gnt_a got %b exp 0", gnt_a);
    end

    // Mid-slot reset while B owns.
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (gnt_b !== 1'b0 || grounds !== 4'hF || display !== 7'h00) begin
      errors++;
      $display("FAIL reset_midslot got gnt_b=%b gnd=%b disp=%b exp 0 1111 0000000",
               gnt_b, grounds, display);
    end
    repeat (40) @(negedge clk);

    // Random traffic, including short pulses and rare resets.
    repeat (2000) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) req_a = ~req_a;
      if ($urandom_range(0, 19) == 0) req_b = ~req_b;
      if ($urandom_range(0, 7) == 0)  val_a = 16'($urandom);
      if ($urandom_range(0, 7) == 0)  val_b = 16'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
    end
    rst_n = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Time-multiplexed 4-digit seven-segment scan controller that shares the board display between two requesters (A and B). It arbitrates ownership only at frame boundaries, latches the owner's 16-bit value once per frame, and drives active-low digit grounds with inter-digit blanking to avoid ghosting. It sits between the value-producing blocks (switch counters, status sources) and the display pins, replacing per-module scan logic.

## Interface
- SCAN_DIV, 65536: clk cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 256: cycles at the start of each slot with all digits off; must be < SCAN_DIV.
- HOLD_FRAMES, 8: minimum frames an owner keeps the display while the other side is requesting; must be >= 1.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_a  in  1  requester A wants the display (level).
- val_a  in  16  requester A value; [15:12] is the leftmost digit.
- req_b  in  1  requester B wants the display (level).
- val_b  in  16  requester B value.
- gnt_a  out  1  A currently owns the display.
- gnt_b  out  1  B currently owns the display.
- display  out  7  segments {a,b,c,d,e,f,g}, active-high.
- grounds  out  4  digit enables, active-low.
- frame_tick  out  1  one-cycle pulse at the end of each 4-digit frame.

## Operation
- Scan counters: div_cnt counts 0..SCAN_DIV-1 and wraps. idx (2 bits) increments when div_cnt wraps, with 3 wrapping to 0.
- Frame end: the cycle where idx==3 and div_cnt==SCAN_DIV-1. This is the only cycle in which arbitration state, gnt_* and shadow may change.
- Digit select, outside blanking:
  - idx0: grounds 1110, shows shadow[15:12]
  - idx1: grounds 1101, shows shadow[11:8]
  - idx2: grounds 1011, shows shadow[7:4]
  - idx3: grounds 0111, shows shadow[3:0]
- Blanking: while div_cnt < BLANK_CYCLES, grounds=1111 and display=0000000.
- Hex decode:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Idle display: in IDLE, every non-blanked digit shows a dash, 0000001.
- States: IDLE, OWN_A, OWN_B. Register last records the most recently granted side; reset value B. hold_cnt counts completed frames in the current ownership.
- Transitions, evaluated at frame end only:
  - IDLE: req_a&req_b -> grant the side != last; req_a only -> OWN_A; req_b only -> OWN_B; none -> stay IDLE.
  - OWN_X, req_X low: other side requesting -> OWN_other; otherwise -> IDLE. HOLD_FRAMES does not apply on release.
  - OWN_X, req_X high, other side requesting, hold_cnt >= HOLD_FRAMES-1 -> OWN_other.
  - OWN_X, any other case -> stay in OWN_X, hold_cnt saturating increment.
  - On any transition into an OWN state: hold_cnt=0 and last=new owner.
- Shadow latch: at frame end, shadow <= value of the next-state owner (val_a or val_b sampled that cycle). If the next state is IDLE, shadow keeps its value and dashes are shown. A frame never mixes two values.
- gnt_a/gnt_b are one-hot or both 0, registered, and equal to the state.

## Timing
- Reset: while rst_n is sampled low, the block holds:
  - div_cnt=0, idx=0, state=IDLE, last=B, hold_cnt=0, shadow=0
  - gnt_a=gnt_b=0, grounds=1111, display=0000000, frame_tick=0
- Reset applies on the next edge regardless of frame position. Mid-frame reset restarts the frame; no partial grant survives.
- Cycle 0 is the first edge with rst_n sampled high. Counter values are the pre-edge values.
- All outputs are registered with 1-cycle latency: outputs after edge k reflect div_cnt/idx/state/shadow before edge k.
- Slot s (s=0..3) occupies counter cycles [s*SCAN_DIV, (s+1)*SCAN_DIV). The frame is 4*SCAN_DIV cycles.
- frame_tick is high for exactly one cycle per frame, in the cycle after the frame-end counter state.
- gnt_* and the new shadow take effect with the first slot of the next frame. Req-to-grant latency is at most one frame plus 1 cycle.
- Requests and values are sampled only at frame end. A request pulse shorter than a frame that misses frame end is ignored.

## Test plan
Params SCAN_DIV=8, BLANK_CYCLES=2, HOLD_FRAMES=2; frame = 32 cycles.
- Reset/idle, no requests -> per slot: 2 cycles of grounds 1111/display 0, then 6 cycles of display 0000001 on 1110, 1101, 1011, 0111 in turn; frame_tick pulses every 32 cycles; gnt_a=gnt_b=0.
- req_a=1, val_a=16'h1A3F from cycle 0 -> gnt_a=1 after the first frame_tick. The next frame shows 0110000, 1110111, 1111001, 1000111 on 1110, 1101, 1011, 0111.
- req_a=req_b=1 from cycle 0 (val_a=16'h1111, val_b=16'h2222) -> A wins first. Ownership alternates every 2 frames (A,A,B,B,A,...), and gnt_* is never both 1.
- While A owns, change val_a to 16'hBEEF mid-frame -> the current frame keeps the old digits; BEEF (0011111, 1001111, 1001111, 1000111) appears from the next frame.
- A owns for 0 frames, B requesting, req_a drops -> gnt_b=1 at the next frame end despite HOLD_FRAMES; gnt_a=0 in the same cycle.
- rst_n low for 1 cycle mid-slot while B owns -> next cycle gnt_b=0, grounds=1111, display=0; the scan restarts at slot 0 and the first frame after reset shows dashes.
